// File: rtl/multicycle_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_pkg
// Shared definitions for the multicycle control unit:
//   - state_e      : control FSM state encoding (TRAP exists only when
//                    ILLEGAL_OP_TRAP_EN is defined)
//   - OP_*         : instruction opcode field values (IR[31:26])
//   - FUNCT_*      : R-type funct field values (IR[5:0])
//   - ALU_*        : 3-bit ALU operation codes driven to the ALU
//   - SRCB_*/PCSRC_* : datapath mux select values
//   - is_terminal(): true for the last state of every legal instruction
// -----------------------------------------------------------------------------
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
`ifdef ILLEGAL_OP_TRAP_EN
        , S_TRAP
`endif
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_XOR = 6'h26;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // An instruction retires when the FSM leaves one of these states.
    function automatic logic is_terminal(input state_e s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) ||
               (s == S_BRANCH) || (s == S_ADDIWB) || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/alu_funct_decoder.sv
// -----------------------------------------------------------------------------
// alu_funct_decoder
// Combinational map from the R-type funct field to the 3-bit ALU op code.
// Unknown funct values fall back to ADD.
// Ports:
//   funct  in  6  IR[5:0]
//   alu_op out 3  ALU operation code for the EXEC state
// -----------------------------------------------------------------------------
module alu_funct_decoder
    import multicycle_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op
);

    always_comb begin
        unique case (funct)
            FUNCT_ADD: alu_op = ALU_ADD;
            FUNCT_SUB: alu_op = ALU_SUB;
            FUNCT_AND: alu_op = ALU_AND;
            FUNCT_OR:  alu_op = ALU_OR;
            FUNCT_XOR: alu_op = ALU_XOR;
            FUNCT_NOR: alu_op = ALU_NOR;
            FUNCT_SLT: alu_op = ALU_SLT;
            default:   alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Moore control FSM for a multicycle datapath plus a retired-instruction
// counter. Outputs depend on state only, except AluOp in EXEC (from Funct)
// and PCEn in BRANCH (from ZeroFlag).
// Optional build macro: ILLEGAL_OP_TRAP_EN adds the IllegalOp output and a
// TRAP state entered on an unknown opcode and left only by reset.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   Opcode, Funct         IR[31:26], IR[5:0]
//   ZeroFlag              ALU zero flag, same cycle
//   AluOp, AluSrcA/B      ALU operation and operand selects
//   PCSrc, PCEn           PC source select and write enable
//   IorD, MemRead/Write   memory address select and strobes
//   IRWrite               instruction register load
//   RegDst, MemtoReg, RegWrite  register-file write controls
//   IllegalOp             (ILLEGAL_OP_TRAP_EN only) FSM is in TRAP
//   InstrCount            retired-instruction count, wraps modulo 2^COUNT_W
// -----------------------------------------------------------------------------
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         Funct,
    input  logic               ZeroFlag,
    output logic [2:0]         AluOp,
    output logic               AluSrcA,
    output logic [1:0]         AluSrcB,
    output logic [1:0]         PCSrc,
    output logic               PCEn,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic               IllegalOp,
`endif
    output logic [COUNT_W-1:0] InstrCount
);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [2:0]         exec_alu_op;

    alu_funct_decoder u_funct_dec (
        .funct  (Funct),
        .alu_op (exec_alu_op)
    );

    always_comb begin
        // NOTE: every output gets a default before the case so that states
        // which do not mention a signal drive 0 instead of inferring a latch.
        state_d  = S_FETCH;
        count_d  = count_q;
        AluOp    = ALU_AND;
        AluSrcA  = 1'b0;
        AluSrcB  = SRCB_REGB;
        PCSrc    = PCSRC_ALU;
        PCEn     = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
        IllegalOp = 1'b0;
`endif

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                AluSrcB = SRCB_FOUR;
                AluOp   = ALU_ADD;
                PCSrc   = PCSRC_ALU;
                PCEn    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed speculatively while decoding.
                AluSrcB = SRCB_IMM_SH2;
                AluOp   = ALU_ADD;
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                AluSrcA = 1'b1;
                AluSrcB = SRCB_IMM;
                AluOp   = ALU_ADD;
                state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                AluSrcA = 1'b1;
                AluSrcB = SRCB_REGB;
                AluOp   = exec_alu_op;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                AluSrcA = 1'b1;
                AluSrcB = SRCB_REGB;
                AluOp   = ALU_SUB;
                PCSrc   = PCSRC_ALUOUT;
                PCEn    = ZeroFlag;
            end
            S_ADDIEX: begin
                AluSrcA = 1'b1;
                AluSrcB = SRCB_IMM;
                AluOp   = ALU_ADD;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCSrc = PCSRC_JUMP;
                PCEn  = 1'b1;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP: begin
                IllegalOp = 1'b1;
                state_d   = S_TRAP;
            end
`endif
            default: state_d = S_FETCH;
        endcase

        // Every terminal state returns to FETCH, so leaving it retires one
        // instruction. The illegal DECODE->FETCH path is not terminal.
        if (is_terminal(state_q)) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign InstrCount = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Self-checking bench for multicycle_control. Each instruction is described
// as the list of control words it must produce cycle by cycle; the retired
// count is tracked as a plain integer modulo 2^CW. A narrow counter (CW=4)
// makes wrap-around happen within the random run.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [5:0]    Opcode = 6'd0;
    logic [5:0]    Funct = 6'd0;
    logic          ZeroFlag = 1'b0;
    logic [2:0]    AluOp;
    logic          AluSrcA;
    logic [1:0]    AluSrcB;
    logic [1:0]    PCSrc;
    logic          PCEn, IorD, MemRead, MemWrite, IRWrite;
    logic          RegDst, MemtoReg, RegWrite;
    logic [CW-1:0] InstrCount;
`ifdef ILLEGAL_OP_TRAP_EN
    logic          IllegalOp;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int model_cnt = 0;

    multicycle_control #(.COUNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .Opcode     (Opcode),
        .Funct      (Funct),
        .ZeroFlag   (ZeroFlag),
        .AluOp      (AluOp),
        .AluSrcA    (AluSrcA),
        .AluSrcB    (AluSrcB),
        .PCSrc      (PCSrc),
        .PCEn       (PCEn),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
`ifdef ILLEGAL_OP_TRAP_EN
        .IllegalOp  (IllegalOp),
`endif
        .InstrCount (InstrCount)
    );

    always #5 clk = ~clk;

    // Control word layout shared by observation and expectation.
    logic [15:0] obs;
    assign obs = {AluOp, AluSrcA, AluSrcB, PCSrc, PCEn, IorD, MemRead,
                  MemWrite, IRWrite, RegDst, MemtoReg, RegWrite};

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] ctl(
        input logic [2:0] op, input logic sa, input logic [1:0] sb,
        input logic [1:0] ps, input logic pe, input logic iord,
        input logic mr, input logic mw, input logic irw,
        input logic rd, input logic m2r, input logic rw);
        return {op, sa, sb, ps, pe, iord, mr, mw, irw, rd, m2r, rw};
    endfunction

    function automatic logic [2:0] funct_op(input logic [5:0] f);
        case (f)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h26:   return 3'b101;
            6'h27:   return 3'b100;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                          6'b001000, 6'b000010};
    endfunction

    // Cycles from FETCH up to and including the last state of the instruction.
    function automatic int latency(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000000: return 4;
            6'b001000: return 4;
            6'b000100: return 3;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    // Expected control word for cycle 'step' of an instruction.
    function automatic logic [15:0] expect_ctl(input logic [5:0] op,
                                               input logic [5:0] f,
                                               input int step, input logic z);
        logic [15:0] fetch_w, decode_w, memadr_w;
        fetch_w  = ctl(3'b010, 0, 2'b01, 2'b00, 1, 0, 1, 0, 1, 0, 0, 0);
        decode_w = ctl(3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        memadr_w = ctl(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        if (step == 0) return fetch_w;
        if (step == 1) return decode_w;
        case (op)
            6'b100011: begin
                if (step == 2) return memadr_w;
                if (step == 3) return ctl(3'b000, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0);
                return ctl(3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1);
            end
            6'b101011: begin
                if (step == 2) return memadr_w;
                return ctl(3'b000, 0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0);
            end
            6'b000000: begin
                if (step == 2) return ctl(funct_op(f), 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
                return ctl(3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1);
            end
            6'b001000: begin
                if (step == 2) return memadr_w;
                return ctl(3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
            end
            6'b000100: return ctl(3'b110, 1, 2'b00, 2'b01, z, 0, 0, 0, 0, 0, 0, 0);
            6'b000010: return ctl(3'b000, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0);
            default:   return 16'h0000;
        endcase
    endfunction

    // Runs one instruction starting in its FETCH cycle. Enters and leaves just
    // after a falling edge. zmode: 0/1 forces ZeroFlag, 2 randomises it every
    // cycle. abort_at >= 0 asserts reset during that step.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f,
                             input int zmode, input int abort_at);
        int n;
        n = latency(op);
        for (int s = 0; s < n; s++) begin
            Opcode   = op;
            Funct    = f;
            ZeroFlag = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            check($sformatf("ctl op=%b f=%h step=%0d", op, f, s), 32'(obs),
                  32'(expect_ctl(op, f, s, ZeroFlag)));
            check($sformatf("cnt op=%b step=%0d", op, s), 32'(InstrCount),
                  32'(model_cnt));
`ifdef ILLEGAL_OP_TRAP_EN
            check("illegal_low", 32'(IllegalOp), 32'd0);
`endif
            if (s == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                #1;
                check("abort_fetch", 32'(obs),
                      32'(expect_ctl(op, f, 0, 1'b0)));
                check("abort_cnt", 32'(InstrCount), 32'd0);
                reset = 1'b0;
                model_cnt = 0;
                return;
            end
            @(negedge clk);
        end
        if (is_legal(op)) begin
            model_cnt = (model_cnt + 1) % (1 << CW);
        end
`ifdef ILLEGAL_OP_TRAP_EN
        else begin
            for (int t = 0; t < 10; t++) begin
                ZeroFlag = 1'($urandom_range(0, 1));
                Opcode   = 6'($urandom);
                #1;
                check("trap_ctl", 32'(obs), 32'd0);
                check("trap_flag", 32'(IllegalOp), 32'd1);
                check("trap_cnt", 32'(InstrCount), 32'(model_cnt));
                @(negedge clk);
            end
            reset = 1'b1;
            @(negedge clk);
            #1;
            check("trap_clear", 32'(IllegalOp), 32'd0);
            check("trap_rst_cnt", 32'(InstrCount), 32'd0);
            reset = 1'b0;
            model_cnt = 0;
        end
`endif
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] fns [8];
        logic [5:0] op, f;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                6'b001000, 6'b000010, 6'b111111};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h3F};

        // Reset held for two rising edges.
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_ctl", 32'(obs),
              32'(ctl(3'b010, 0, 2'b01, 2'b00, 1, 0, 1, 0, 1, 0, 0, 0)));
        check("reset_cnt", 32'(InstrCount), 32'd0);

        // Directed instructions.
        run_instr(6'b000000, 6'h22, 2, -1);   // sub
        run_instr(6'b100011, 6'h00, 2, -1);   // lw
        run_instr(6'b101011, 6'h00, 2, -1);   // sw
        run_instr(6'b000100, 6'h00, 1, -1);   // beq taken
        run_instr(6'b000100, 6'h00, 0, -1);   // beq not taken
        run_instr(6'b001000, 6'h00, 2, -1);   // addi
        run_instr(6'b000010, 6'h00, 2, -1);   // j
        run_instr(6'b100011, 6'h00, 2, 3);    // lw, reset in MEMRD
        check("cnt_after_abort", 32'(InstrCount), 32'd0);
`ifndef ILLEGAL_OP_TRAP_EN
        run_instr(6'b111111, 6'h00, 2, -1);   // illegal, silent return
`endif
        run_instr(6'b000000, 6'h2A, 2, -1);   // slt

        // Random legal mix long enough to wrap the counter more than once.
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 5)];
            f  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
`ifndef ILLEGAL_OP_TRAP_EN
            if ($urandom_range(0, 7) == 0) op = 6'b111111;
`endif
            run_instr(op, f, 2, -1);
        end

`ifdef ILLEGAL_OP_TRAP_EN
        run_instr(6'b111111, 6'h00, 2, -1);   // enters TRAP, then reset
        run_instr(6'b000000, 6'h20, 2, -1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
